// File: rtl/host_mem_loader_pkg.sv
// Shared types and constants for the host memory loader.
//   loader_state_t : loader FSM state encoding (also exported on the debug port)
//   OP_*           : command-word opcodes carried in bits [15:12]
package host_mem_loader_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ADDR = 3'd1,
    IHI  = 3'd2,
    ILO  = 3'd3,
    DDAT = 3'd4,
    RUN  = 3'd5
  } loader_state_t;

  localparam logic [3:0] OP_LOAD_IMEM = 4'h1;
  localparam logic [3:0] OP_LOAD_DMEM = 4'h2;
  localparam logic [3:0] OP_RUN       = 4'h3;

endpackage

// File: rtl/host_mem_loader.sv
// Host-side loader. Consumes a 16-bit command/data stream from the host and
// writes it into instruction memory (two words per instruction, high first)
// or data memory, then releases the core and waits for its end indication.
//
// Ports
//   clk, reset            : clock, asynchronous active-low reset
//   host_valid/host_ready : stream handshake, host_data carries the word
//   imem_we/addr/wdata    : IMem write port (registered, one-cycle strobe)
//   dmem_we/addr/wdata    : DMem write port (registered, one-cycle strobe)
//   core_run              : 1 while the core is released
//   core_end              : core finished its kernel (only observed in RUN)
//   done                  : one-cycle pulse when RUN returns to IDLE
//   err                   : sticky error (bad opcode, oversize address, wrap)
//   dbg_state             : current FSM state, for observation only
//
// Handshake: a word is transferred on a rising edge where host_valid and
// host_ready are both 1; host_ready is registered and is 0 only in RUN
// (and while reset is applied), so it never depends on host_valid.
module host_mem_loader
  import host_mem_loader_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int INSTR_W = 32,
  parameter int IADDR_W = 8,
  parameter int DADDR_W = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               host_valid,
  output logic               host_ready,
  input  logic [DATA_W-1:0]  host_data,
  output logic               imem_we,
  output logic [IADDR_W-1:0] imem_addr,
  output logic [INSTR_W-1:0] imem_wdata,
  output logic               dmem_we,
  output logic [DADDR_W-1:0] dmem_addr,
  output logic [DATA_W-1:0]  dmem_wdata,
  output logic               core_run,
  input  logic               core_end,
  output logic               done,
  output logic               err,
  output logic [2:0]         dbg_state
);

  loader_state_t      r_state;
  logic               r_ready;
  logic               r_load_imem;  // which memory the current load targets
  logic [11:0]        r_cnt;
  logic [IADDR_W-1:0] r_iaddr;
  logic [DADDR_W-1:0] r_daddr;
  logic [DATA_W-1:0]  r_hi;
  logic               r_imem_we;
  logic [IADDR_W-1:0] r_imem_addr;
  logic [INSTR_W-1:0] r_imem_wdata;
  logic               r_dmem_we;
  logic [DADDR_W-1:0] r_dmem_addr;
  logic [DATA_W-1:0]  r_dmem_wdata;
  logic               r_core_run;
  logic               r_done;
  logic               r_err;

  logic               w_fire;
  logic [3:0]         w_op;

  assign w_fire = host_valid & r_ready;
  assign w_op   = host_data[15:12];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= IDLE;
      r_ready      <= 1'b0;
      r_load_imem  <= 1'b0;
      r_cnt        <= '0;
      r_iaddr      <= '0;
      r_daddr      <= '0;
      r_hi         <= '0;
      r_imem_we    <= 1'b0;
      r_imem_addr  <= '0;
      r_imem_wdata <= '0;
      r_dmem_we    <= 1'b0;
      r_dmem_addr  <= '0;
      r_dmem_wdata <= '0;
      r_core_run   <= 1'b0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_imem_we <= 1'b0;
      r_dmem_we <= 1'b0;
      r_done    <= 1'b0;
      // Ready is high everywhere but RUN; the IDLE->RUN branch overrides this.
      if (r_state != RUN) r_ready <= 1'b1;

      case (r_state)
        IDLE: begin
          if (w_fire) begin
            case (w_op)
              OP_LOAD_IMEM: begin
                r_load_imem <= 1'b1;
                r_cnt       <= host_data[11:0];
                r_state     <= ADDR;
              end
              OP_LOAD_DMEM: begin
                r_load_imem <= 1'b0;
                r_cnt       <= host_data[11:0];
                r_state     <= ADDR;
              end
              OP_RUN: begin
                r_core_run <= 1'b1;
                r_ready    <= 1'b0;
                r_state    <= RUN;
              end
              default: r_err <= 1'b1;
            endcase
          end
        end

        ADDR: begin
          if (w_fire) begin
            if (r_load_imem) begin
              r_iaddr <= host_data[IADDR_W-1:0];
              if (|host_data[DATA_W-1:IADDR_W]) r_err <= 1'b1;
            end else begin
              r_daddr <= host_data[DADDR_W-1:0];
              if (|host_data[DATA_W-1:DADDR_W]) r_err <= 1'b1;
            end
            if (r_cnt == 12'd0)   r_state <= IDLE;
            else if (r_load_imem) r_state <= IHI;
            else                  r_state <= DDAT;
          end
        end

        IHI: begin
          if (w_fire) begin
            r_hi    <= host_data;
            r_state <= ILO;
          end
        end

        ILO: begin
          if (w_fire) begin
            r_imem_we    <= 1'b1;
            r_imem_addr  <= r_iaddr;
            r_imem_wdata <= {r_hi, host_data};
            r_iaddr      <= r_iaddr + 1'b1;
            r_cnt        <= r_cnt - 12'd1;
            // A wrap is an error only when another item follows at address 0.
            if ((&r_iaddr) && (r_cnt != 12'd1)) r_err <= 1'b1;
            r_state <= (r_cnt == 12'd1) ? IDLE : IHI;
          end
        end

        DDAT: begin
          if (w_fire) begin
            r_dmem_we    <= 1'b1;
            r_dmem_addr  <= r_daddr;
            r_dmem_wdata <= host_data;
            r_daddr      <= r_daddr + 1'b1;
            r_cnt        <= r_cnt - 12'd1;
            if ((&r_daddr) && (r_cnt != 12'd1)) r_err <= 1'b1;
            if (r_cnt == 12'd1) r_state <= IDLE;
          end
        end

        RUN: begin
          if (core_end) begin
            r_core_run <= 1'b0;
            r_done     <= 1'b1;
            r_ready    <= 1'b1;
            r_state    <= IDLE;
          end
        end

        default: r_state <= IDLE;
      endcase
    end
  end

  assign host_ready = r_ready;
  assign imem_we    = r_imem_we;
  assign imem_addr  = r_imem_addr;
  assign imem_wdata = r_imem_wdata;
  assign dmem_we    = r_dmem_we;
  assign dmem_addr  = r_dmem_addr;
  assign dmem_wdata = r_dmem_wdata;
  assign core_run   = r_core_run;
  assign done       = r_done;
  assign err        = r_err;
  assign dbg_state  = r_state;

endmodule
